// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and FSM state type for the digit-serial BCD ALU
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bcd_state_t;

endpackage

// File: rtl/bcd_digit_addsub.sv
// rtl/bcd_digit_addsub.sv - combinational one-digit BCD add/subtract cell
//
// Ports:
//   x, y  in   BCD digits
//   sub   in   0: x+y+cin, 1: x-y-cin
//   cin   in   incoming carry (add) or borrow (sub)
//   s     out  result digit, mod 10
//   cout  out  outgoing carry (add) or borrow (sub)
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             sub,
    input  logic             cin,
    output logic [BCD_W-1:0] s,
    output logic             cout
);

    // One extra bit: the sum reaches at most 31 and the difference
    // lies in -16..15 even for illegal (>9) digits.
    logic [BCD_W:0] sum;
    logic [BCD_W:0] diff;

    always_comb begin
        sum  = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, cin};
        diff = {1'b0, x} - {1'b0, y} - {{BCD_W{1'b0}}, cin};
        s    = '0;
        cout = 1'b0;
        if (!sub) begin
            if (sum > {1'b0, BCD_MAX}) begin
                cout = 1'b1;
                // low nibble of (sum - 10) equals low nibble minus 10 mod 16
                s    = sum[BCD_W-1:0] - 4'd10;
            end else begin
                s    = sum[BCD_W-1:0];
            end
        end else begin
            // sign bit of the two's-complement difference is the borrow
            cout = diff[BCD_W];
            s    = diff[BCD_W] ? (diff[BCD_W-1:0] + 4'd10) : diff[BCD_W-1:0];
        end
    end

endmodule

// File: rtl/bcd_serial_alu.sv
// rtl/bcd_serial_alu.sv - digit-serial BCD add/subtract controller, one digit per clock
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b, sub)
//   out_valid/out_ready  result handshake (o, cout)
//   o                    packed-BCD result modulo 10^DIGITS
//   cout                 final carry (add) or borrow (sub)
module bcd_serial_alu
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] o,
    output logic                    cout
);

    localparam int W     = BCD_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    bcd_state_t       state;
    bcd_state_t       next_state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             sub_q;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     res;

    logic             accept;
    logic             step;
    logic [BCD_W-1:0] x_d;
    logic [BCD_W-1:0] y_d;
    logic [BCD_W-1:0] s_d;
    logic             c_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Select the current digit pair from the latched operands.
    always_comb begin
        x_d = '0;
        y_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(idx) == i) begin
                x_d = a_q[i*BCD_W +: BCD_W];
                y_d = b_q[i*BCD_W +: BCD_W];
            end
        end
    end

    bcd_digit_addsub u_cell (
        .x    (x_d),
        .y    (y_d),
        .sub  (sub_q),
        .cin  (carry),
        .s    (s_d),
        .cout (c_d)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            res   <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            idx   <= '0;
            carry <= 1'b0;
            res   <= '0;
        end else if (step) begin
            carry <= c_d;
            idx   <= idx + IDX_W'(1);
            for (int i = 0; i < DIGITS; i++) begin
                if (int'(idx) == i) begin
                    res[i*BCD_W +: BCD_W] <= s_d;
                end
            end
        end
    end

    // The carry register holds the final carry/borrow once RUN ends.
    assign o    = res;
    assign cout = carry;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// tb/tb_bcd_serial_alu.sv - scoreboard bench for bcd_serial_alu at DIGITS=4 and DIGITS=1
module tb_bcd_serial_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic nrst;

    logic        in_valid4, in_ready4, sub4, out_valid4, out_ready4, cout4;
    logic [15:0] a4, b4, o4;
    logic        in_valid1, in_ready1, sub1, out_valid1, out_ready1, cout1;
    logic [3:0]  a1, b1, o1;

    int cmp = 0;
    int err = 0;

    logic [63:0] q4_o[$];
    logic        q4_c[$];
    logic [63:0] q1_o[$];
    logic        q1_c[$];

    bcd_serial_alu #(.DIGITS(4)) dut4 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
        .o(o4), .cout(cout4)
    );

    bcd_serial_alu #(.DIGITS(1)) dut1 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
        .o(o1), .cout(cout1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        cmp++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        cmp++;
        err++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference model: decimal arithmetic on whole numbers.
    function automatic longint bcd2int(input logic [63:0] v, input int d);
        longint r = 0;
        for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] int2bcd(input longint v, input int d);
        logic [63:0] r = '0;
        longint t = v;
        for (int i = 0; i < d; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model(input logic [63:0] av, input logic [63:0] bv, input logic s,
                         input int d, output logic [63:0] ov, output logic cv);
        longint pw = 1;
        longint r;
        for (int i = 0; i < d; i++) pw = pw * 10;
        if (!s) begin
            r  = bcd2int(av, d) + bcd2int(bv, d);
            cv = (r >= pw);
            ov = int2bcd(r % pw, d);
        end else begin
            r  = bcd2int(av, d) - bcd2int(bv, d);
            cv = (r < 0);
            if (r < 0) r = r + pw;
            ov = int2bcd(r, d);
        end
    endtask

    function automatic logic [15:0] rand_bcd4();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(9));
        return v;
    endfunction

    // Monitors: compare whenever a result is consumed.
    always @(negedge clk) begin
        if (nrst && out_valid4 && out_ready4) begin
            if (q4_o.size() == 0) begin
                fail_now("unexpected_result4");
            end else begin
                chk("o4", longint'(o4), longint'(q4_o.pop_front()));
                chk("cout4", longint'(cout4), longint'(q4_c.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (nrst && out_valid1 && out_ready1) begin
            if (q1_o.size() == 0) begin
                fail_now("unexpected_result1");
            end else begin
                chk("o1", longint'(o1), longint'(q1_o.pop_front()));
                chk("cout1", longint'(cout1), longint'(q1_c.pop_front()));
            end
        end
    end

    task automatic op4(input logic [15:0] av, input logic [15:0] bv, input logic s,
                       input bit check_lat, input bit rand_bp);
        logic [63:0] eo;
        logic        ec;
        int          n;
        bit          done;
        n = 0;
        while (!in_ready4 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready4) begin fail_now("wait_in_ready4"); return; end
        a4 = av; b4 = bv; sub4 = s; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        model({48'd0, av}, {48'd0, bv}, s, 4, eo, ec);
        q4_o.push_back(eo);
        q4_c.push_back(ec);
        a4 = 16'($urandom); b4 = 16'($urandom); sub4 = 1'($urandom);
        n = 0;
        while (!out_valid4 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!out_valid4) begin fail_now("wait_out_valid4"); return; end
        if (check_lat) chk("latency4", n, 4);
        done = 1'b0;
        while (!done) begin
            out_ready4 = rand_bp ? 1'($urandom) : 1'b1;
            done = out_ready4;
            @(posedge clk); #1;
        end
        out_ready4 = 1'b0;
    endtask

    task automatic op1(input logic [3:0] av, input logic [3:0] bv, input logic s,
                       input bit check_lat);
        logic [63:0] eo;
        logic        ec;
        int          n;
        n = 0;
        while (!in_ready1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready1) begin fail_now("wait_in_ready1"); return; end
        a1 = av; b1 = bv; sub1 = s; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        model({60'd0, av}, {60'd0, bv}, s, 1, eo, ec);
        q1_o.push_back(eo);
        q1_c.push_back(ec);
        n = 0;
        while (!out_valid1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!out_valid1) begin fail_now("wait_out_valid1"); return; end
        if (check_lat) chk("latency1", n, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] eo;
        logic        ec;
        int          n;

        nrst = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; out_ready4 = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready4", in_ready4, 1);
        chk("rst_out_valid4", out_valid4, 0);
        chk("rst_o4", o4, 0);
        chk("rst_cout4", cout4, 0);
        chk("rst_in_ready1", in_ready1, 1);
        chk("rst_out_valid1", out_valid1, 0);
        nrst = 1'b1;
        @(posedge clk); #1;

        // directed corner cases
        op4(16'h0999, 16'h0001, 1'b0, 1, 0);
        op4(16'h9999, 16'h0001, 1'b0, 1, 0);
        op4(16'h4567, 16'h5432, 1'b0, 1, 0);
        op4(16'h1000, 16'h0001, 1'b1, 1, 0);
        op4(16'h0000, 16'h0001, 1'b1, 1, 0);
        op4(16'h9999, 16'h9999, 1'b0, 1, 0);

        // backpressure: result must hold, no second accept
        a4 = 16'h1234; b4 = 16'h5678; sub4 = 1'b0; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        model(64'h1234, 64'h5678, 1'b0, 4, eo, ec);
        q4_o.push_back(eo);
        q4_c.push_back(ec);
        n = 0;
        while (!out_valid4 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_latency", n, 4);
        repeat (5) begin
            in_valid4 = ~in_valid4;
            a4 = 16'($urandom);
            @(posedge clk); #1;
            chk("bp_o", o4, eo[15:0]);
            chk("bp_cout", cout4, ec);
            chk("bp_in_ready", in_ready4, 0);
            chk("bp_out_valid", out_valid4, 1);
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        chk("rel_in_ready", in_ready4, 1);
        chk("rel_out_valid", out_valid4, 0);

        // reset mid-RUN aborts without any result
        a4 = 16'h5555; b4 = 16'h4444; sub4 = 1'b0; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk("abort_out_valid", out_valid4, 0);
        chk("abort_in_ready", in_ready4, 1);
        chk("abort_o", o4, 0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("abort_hold_valid", out_valid4, 0);
        end
        nrst = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_pulse", out_valid4, 0);
        end
        out_ready4 = 1'b0;
        op4(16'h0001, 16'h0001, 1'b0, 1, 0);

        // randomized operations with random backpressure
        for (int i = 0; i < 40; i++) begin
            op4(rand_bcd4(), rand_bcd4(), 1'($urandom), 1, 1);
        end

        // single-digit instance: directed then full sweep
        op1(4'd3, 4'd7, 1'b1, 1);
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 10; x++) begin
                for (int y = 0; y < 10; y++) begin
                    op1(4'(x), 4'(y), 1'(s), 0);
                end
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("q4_drained", q4_o.size(), 0);
        chk("q1_drained", q1_o.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule

// File: doc/bcd_serial_alu.md
# bcd_serial_alu

Digit-serial BCD add/subtract controller. Accepts two DIGITS-wide packed-BCD operands and an add/sub select through a valid/ready handshake. Sequences a single shared one-digit BCD add/sub cell from the least-significant digit upward, one digit per clock, carrying or borrowing between digits. Returns the result and a final carry/borrow flag through a second valid/ready handshake. It replaces a wide combinational BCD adder where area matters more than latency.

## Interface
Parameters:
- DIGITS, default 4: number of BCD digits per operand; legal range 1..16.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands and sub are valid.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- a  in  4*DIGITS  packed-BCD operand A; digit i is a[4i+3:4i].
- b  in  4*DIGITS  packed-BCD operand B.
- sub  in  1  0 selects a+b; 1 selects a−b.
- out_valid  out  1  o and cout hold a completed result.
- out_ready  in  1  consumer takes the result.
- o  out  4*DIGITS  packed-BCD result, modulo 10^DIGITS.
- cout  out  1  for add, 1 when a+b ≥ 10^DIGITS; for sub, 1 when a < b (borrow).

## Operation
- Three-state FSM:
  - IDLE: in_ready=1, out_valid=0. On in_valid & in_ready, latch a, b and sub, clear the digit index and carry, clear the result register, and go to RUN.
  - RUN: each cycle, feed latched digit[idx] of A and B, the latched sub and the carry register to the digit cell. Write the cell sum into result digit idx, write the cell carry/borrow into the carry register, and increment idx. After the cycle with idx = DIGITS−1, go to DONE.
  - DONE: out_valid=1, and o and cout are stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Inputs a, b and sub may change freely after acceptance.
- For sub, o is the ten's-complement difference. For example, 0000−0001 gives 9999 with cout=1.
- Operand digits greater than 9 give an unspecified o and cout. FSM timing is unchanged and the block must not hang.
- The digit cell is combinational:
  - add: s = (x+y+c) mod 10, carry = (x+y+c ≥ 10).
  - sub: s = (x−y−c) mod 10, borrow = (x−y−c < 0).

## Timing
- Reset, asynchronous: state=IDLE, in_ready=1, out_valid=0, o=0, cout=0, idx=0, carry=0.
- Accept at edge k. RUN covers edges k+1 through k+DIGITS. out_valid is high from after edge k+DIGITS.
- Result latency: DIGITS cycles from the accepting edge to out_valid.
- in_ready is low from after edge k until the edge where the result is consumed has passed. A result cannot be consumed and a new operation accepted on the same edge.
- Back-to-back throughput: one operation per DIGITS+2 cycles.
- While out_valid=1 and out_ready=0, o, cout and out_valid hold indefinitely.
- o may change during RUN and is defined only while out_valid=1. It holds its value after consumption until the next accept.
- Reset asserted in RUN or DONE aborts the operation immediately. No out_valid pulse follows.
- DIGITS=1: RUN lasts exactly one cycle.

## Structure
- Package bcd_pkg holds:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - typedef enum logic [1:0] {IDLE, RUN, DONE} bcd_state_t
- Sub-module bcd_digit_addsub (x, y, sub, cin → s, cout) is the combinational digit cell, instantiated once.
- idx width is $clog2(DIGITS), minimum 1.

## Test plan
- DIGITS=4, add, a=0999, b=0001 → o=1000, cout=0, out_valid exactly 4 cycles after the accept edge.
- Add, a=9999, b=0001 → o=0000, cout=1. Add, a=4567, b=5432 → o=9999, cout=0.
- Sub, a=1000, b=0001 → o=0999, cout=0. Sub, a=0000, b=0001 → o=9999, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and toggle in_valid and a during that time → o and cout stable, in_ready=0, no second operation. Release out_ready → in_ready=1 on the next cycle.
- Drive nrst low mid-RUN (after 2 digits), then release and issue add 0001+0001 → out_valid stays 0 during the abort, and the next result is o=0002, cout=0.
- DIGITS=1: sub 3−7 → o=6, cout=1, latency 1 cycle. Sweep all 100×2 digit pairs against a reference model.
